// File: rtl/poly_sched_ctrl.sv
// Stage/round sequencer for a P-lane polynomial engine (NTT, INTT, PWM).
// Issues bank reads per round, delays them into writes, and drains between stages.
module poly_sched_ctrl #(
  parameter int N = 256,
  parameter int P = 4,
  parameter int L = 8,
  localparam int LOGN = $clog2(N),
  localparam int R    = N / (2 * P),
  localparam int IW   = $clog2(LOGN),
  localparam int SW   = $clog2(R)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    opcode,
  input  logic          start,
  input  logic          stall,
  output logic [IW-1:0] i,
  output logic [SW-1:0] s,
  output logic          ren,
  output logic          wen,
  output logic          en,
  output logic          busy,
  output logic          finish,
  output logic          err
);

  localparam int DW = $clog2(L + 2);
  localparam logic [1:0] OP_PWM = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_d;
  logic [IW-1:0] i_d;
  logic [SW-1:0] s_d;
  logic          illegal, illegal_d;
  logic [IW-1:0] last_i, last_i_d;
  logic [DW-1:0] drain_cnt, drain_cnt_d;
  logic [L:0]    dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      s         <= '0;
      illegal   <= 1'b0;
      last_i    <= '0;
      drain_cnt <= '0;
      dly       <= '0;
    end else begin
      state     <= state_d;
      i         <= i_d;
      s         <= s_d;
      illegal   <= illegal_d;
      last_i    <= last_i_d;
      drain_cnt <= drain_cnt_d;
      dly       <= (dly << 1) | (L + 1)'(ren);
    end
  end

  // The drain counter covers L+1 cycles so the stage's last write lands before the next read.
  always_comb begin
    state_d     = state;
    i_d         = i;
    s_d         = s;
    illegal_d   = illegal;
    last_i_d    = last_i;
    drain_cnt_d = drain_cnt;
    ren         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          illegal_d = (opcode == OP_ILL);
          last_i_d  = (opcode == OP_PWM) ? '0 : IW'(LOGN - 1);
          state_d   = (opcode == OP_ILL) ? DONE : RUN;
          i_d       = '0;
          s_d       = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          ren = 1'b1;
          if (s == SW'(R - 1)) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end else begin
            s_d = s + SW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DW'(L)) begin
          if (i == last_i) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            i_d     = i + IW'(1);
            s_d     = '0;
          end
        end else begin
          drain_cnt_d = drain_cnt + DW'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        i_d       = '0;
        s_d       = '0;
        illegal_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wen    = dly[L];
  assign en     = ren | (|dly);
  assign busy   = (state != IDLE);
  assign finish = (state == DONE);
  assign err    = (state == DONE) && illegal;

endmodule

// File: tb/tb_poly_sched_ctrl.sv
// Randomised bench for poly_sched_ctrl at two parameter sets, checked against a
// read-index schedule model derived from the stage/round timing rules.
module tb_poly_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [1:0] opcode = 2'd0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  wire  [1:0] busy_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== 32'(exp)) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int NN  = (g == 0) ? 256 : 64;
    localparam int PP  = (g == 0) ? 4 : 2;
    localparam int LL  = (g == 0) ? 8 : 3;
    localparam int LGN = $clog2(NN);
    localparam int RR  = NN / (2 * PP);

    logic [$clog2(LGN)-1:0] i_o;
    logic [$clog2(RR)-1:0]  s_o;
    logic ren_o, wen_o, en_o, busy_o, finish_o, err_o;

    poly_sched_ctrl #(.N(NN), .P(PP), .L(LL)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .start(start), .stall(stall),
      .i(i_o), .s(s_o), .ren(ren_o), .wen(wen_o), .en(en_o),
      .busy(busy_o), .finish(finish_o), .err(err_o)
    );

    assign busy_w[g] = busy_o;

    bit active = 0, illegal_m = 0, armed = 0;
    int k = 0, tot = 0, allowed = 0, acc_cyc = 0;
    int cnt_ren = 0, cnt_wen = 0, fin_rel = -1;
    bit err_seen = 0;
    bit rd_at[int];

    // Reads are numbered k = 0..S*R-1; read k is stage k/R, round k%R.
    always @(negedge clk) begin
      bit e_ren, e_wen, e_en, e_fin, e_err, e_busy, idle_now;
      int e_i, e_s;
      e_ren = 0; e_fin = 0; e_err = 0; e_busy = 0; e_i = 0; e_s = 0;
      idle_now = !active;
      if (active) begin
        e_busy = 1;
        if (illegal_m) begin
          e_fin = 1;
          e_err = 1;
        end else begin
          e_ren = (k < tot) && (cyc >= allowed) && !stall;
          if (k > 0 && k % RR == 0 && (cyc < allowed || k == tot)) begin
            e_i = (k - 1) / RR;
            e_s = RR - 1;
          end else begin
            e_i = k / RR;
            e_s = k % RR;
          end
          e_fin = (k == tot) && (cyc == allowed);
        end
      end
      e_wen = rd_at.exists(cyc - LL - 1);
      e_en  = e_ren;
      for (int d = 1; d <= LL + 1; d++) if (rd_at.exists(cyc - d)) e_en = 1;

      if (armed) begin
        checkOutput($sformatf("u%0d.ren", g), ren_o, int'(e_ren));
        checkOutput($sformatf("u%0d.wen", g), wen_o, int'(e_wen));
        checkOutput($sformatf("u%0d.en", g), en_o, int'(e_en));
        checkOutput($sformatf("u%0d.busy", g), busy_o, int'(e_busy));
        checkOutput($sformatf("u%0d.finish", g), finish_o, int'(e_fin));
        checkOutput($sformatf("u%0d.err", g), err_o, int'(e_err));
        checkOutput($sformatf("u%0d.i", g), 32'(i_o), e_i);
        checkOutput($sformatf("u%0d.s", g), 32'(s_o), e_s);
      end

      if (ren_o === 1'b1) cnt_ren++;
      if (wen_o === 1'b1) cnt_wen++;
      if (finish_o === 1'b1) fin_rel = cyc - acc_cyc;
      if (err_o === 1'b1) err_seen = 1;

      if (e_ren) begin
        rd_at[cyc] = 1;
        k++;
        if (k % RR == 0) allowed = cyc + LL + 2;
      end
      if (rd_at.exists(cyc - LL - 1)) rd_at.delete(cyc - LL - 1);
      if (e_fin) active = 0;

      if (rst) begin
        active = 0;
        rd_at.delete();
        armed = 1;
      end else if (start && idle_now) begin
        active    = 1;
        illegal_m = (opcode == 2'd3);
        tot       = illegal_m ? 0 : ((opcode == 2'd2) ? 1 : LGN) * RR;
        k         = 0;
        allowed   = cyc + 1;
        acc_cyc   = cyc;
        cnt_ren   = 0;
        cnt_wen   = 0;
        fin_rel   = -1;
        err_seen  = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input int stall_pct, input int stall_from,
                               input int stall_len, input int rst_at, input bit repulse);
    int  t0;
    int  rel;
    bit  done;
    @(posedge clk); #1;
    t0 = cyc; opcode = op; start = 1'b1; stall = 1'b0; rst = 1'b0;
    done = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      if (rel >= 2 && busy_w == 2'b00) begin
        done = 1;
        break;
      end
      start  = repulse && (rel < 90) && (rel % 23 == 4);
      opcode = 2'($urandom_range(3));
      stall  = (rel >= stall_from && rel < stall_from + stall_len) ||
               ($urandom_range(99) < stall_pct);
      rst    = (rel == rst_at);
    end
    checkOutput("job_done", 32'(done), 1);
    start = 1'b0; stall = 1'b0; rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(2'd0, 0, -1, 0, -1, 0);
    checkOutput("ntt.u0.ren_cnt", inst[0].cnt_ren, 256);
    checkOutput("ntt.u0.wen_cnt", inst[0].cnt_wen, 256);
    checkOutput("ntt.u0.finish_at", inst[0].fin_rel, 329);
    checkOutput("ntt.u1.ren_cnt", inst[1].cnt_ren, 96);
    checkOutput("ntt.u1.finish_at", inst[1].fin_rel, 121);

    applyStimulus(2'd2, 0, -1, 0, -1, 0);
    checkOutput("pwm.u0.ren_cnt", inst[0].cnt_ren, 32);
    checkOutput("pwm.u0.wen_cnt", inst[0].cnt_wen, 32);
    checkOutput("pwm.u0.finish_at", inst[0].fin_rel, 42);
    checkOutput("pwm.u1.finish_at", inst[1].fin_rel, 21);

    applyStimulus(2'd0, 0, 130, 5, -1, 0);
    checkOutput("stall.u0.finish_at", inst[0].fin_rel, 334);
    checkOutput("stall.u0.ren_cnt", inst[0].cnt_ren, 256);
    checkOutput("stall.u0.wen_cnt", inst[0].cnt_wen, 256);

    applyStimulus(2'd3, 0, -1, 0, -1, 0);
    checkOutput("ill.u0.ren_cnt", inst[0].cnt_ren, 0);
    checkOutput("ill.u0.finish_at", inst[0].fin_rel, 1);
    checkOutput("ill.u0.err_seen", 32'(inst[0].err_seen), 1);

    applyStimulus(2'd0, 0, -1, 0, 100, 1);
    checkOutput("rst.u0.no_finish", inst[0].fin_rel, -1);

    applyStimulus(2'd1, 0, -1, 0, -1, 0);
    checkOutput("intt.u0.finish_at", inst[0].fin_rel, 329);

    for (int j = 0; j < 8; j++) begin
      applyStimulus(2'($urandom_range(3)), $urandom_range(30), -1, 0,
                    ($urandom_range(3) == 0) ? int'($urandom_range(200, 20)) : -1,
                    1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
